// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, imem handshake FSM and a 2-entry
// {pc4, inst} buffer presented to IF/ID under the shared stall signal.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  if_fetch_unit_if.master   imem,
  output logic [31:0]       if_pc4,
  output logic [31:0]       if_inst,
  output logic              if_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [1:0]  count_reg, count_next, fill_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;

  logic [31:0] pc4_mem  [2];
  logic [31:0] inst_mem [2];

  logic        complete;
  logic        push;
  logic        pop;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;
  assign complete = (state_reg != IDLE) && imem.imem_ack;
  // A redirect flushes the buffer, so it suppresses both push and pop.
  assign push     = !redirect && (state_reg == BUSY) && complete;
  assign pop      = !redirect && !stall && (count_reg != 2'd0);
  assign fill_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc4_mem[wr_ptr_reg]  <= pc_plus4;
      inst_mem[wr_ptr_reg] <= imem.imem_rdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = fill_next;
    rd_ptr_next = rd_ptr_reg ^ pop;
    wr_ptr_next = wr_ptr_reg ^ push;
    if (push) begin
      pc_next = pc_plus4;
    end
    if (redirect) begin
      pc_next     = redirect_pc;
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
      // An in-flight request that survives the redirect must be thrown away.
      if ((state_reg != IDLE) && !complete) begin
        state_next = DROP;
      end else begin
        state_next = BUSY;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          // Only issue when a buffer slot is guaranteed for the response.
          state_next = (fill_next <= 2'd1) ? BUSY : IDLE;
        end
        BUSY: begin
          if (complete) begin
            state_next = (fill_next <= 2'd1) ? BUSY : IDLE;
          end
        end
        DROP: begin
          if (complete) begin
            state_next = BUSY;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (state_reg != IDLE);
  assign imem.imem_addr = pc_reg;

  assign if_valid = (count_reg != 2'd0);
  assign if_inst  = if_valid ? inst_mem[rd_ptr_reg] : 32'h0;
  assign if_pc4   = if_valid ? pc4_mem[rd_ptr_reg]  : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a configurable-latency memory model
// returning mem[a] = a | 32'hA000_0000.
module tb_if_fetch_unit;
  logic        clk;
  logic        clrn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int wait_cnt = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat=0 acks in the first request cycle; lat=N acks in the Nth cycle.
  assign bus.imem_ack   = bus.imem_req && ((lat == 0) || (wait_cnt == lat - 1));
  assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) wait_cnt <= 0;
    else if (bus.imem_req && bus.imem_ack) wait_cnt <= 0;
    else if (bus.imem_req) wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   bus.imem_req,  32'h0);
    check({tag, "_addr"},  bus.imem_addr, 32'h0);
    check({tag, "_valid"}, if_valid,      32'h0);
    check({tag, "_inst"},  if_inst,       32'h0);
    check({tag, "_pc4"},   if_pc4,        32'h0);
  endtask

  initial begin
    clrn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2;
    check_reset("rst0");
    tick(); tick();
    clrn = 1'b1;

    // Zero-wait memory streaming
    tick();
    check("zw_e1_req",  bus.imem_req,  32'h1);
    check("zw_e1_addr", bus.imem_addr, 32'h0);
    tick();
    check("zw_inst0", if_inst, 32'hA000_0000);
    check("zw_pc4_0", if_pc4,  32'h4);
    check("zw_addr0", bus.imem_addr, 32'h4);
    tick();
    check("zw_inst1", if_inst, 32'hA000_0004);
    check("zw_pc4_1", if_pc4,  32'h8);
    check("zw_addr1", bus.imem_addr, 32'h8);

    // Stall with head at pc4=8
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_inst", if_inst, 32'hA000_0004);
      check("st_pc4",  if_pc4,  32'h8);
    end
    check("st_req_drop", bus.imem_req, 32'h0);
    check("st_valid",    if_valid,     32'h1);
    stall = 1'b0;
    tick();
    check("st_rel_inst", if_inst, 32'hA000_0008);
    check("st_rel_pc4",  if_pc4,  32'hC);
    check("st_rel_req",  bus.imem_req, 32'h1);
    check("st_rel_addr", bus.imem_addr, 32'hC);
    tick();
    check("st_rel_inst2", if_inst, 32'hA000_000C);
    check("st_rel_pc42",  if_pc4,  32'h10);

    // Reset mid-request, then switch to a 3-cycle memory
    stall = 1'b1;
    lat = 3;
    tick();
    check("mr_req",  bus.imem_req,  32'h1);
    check("mr_addr", bus.imem_addr, 32'h10);
    check("mr_inst", if_inst,       32'hA000_000C);
    clrn = 1'b0;
    #1;
    check_reset("rst1");
    tick();
    clrn = 1'b1;
    stall = 1'b0;

    // 3-cycle memory
    tick();
    check("l3_e1_req",  bus.imem_req,  32'h1);
    check("l3_e1_addr", bus.imem_addr, 32'h0);
    check("l3_e1_valid", if_valid,     32'h0);
    tick();
    check("l3_e2_addr", bus.imem_addr, 32'h0);
    tick();
    check("l3_e3_addr",  bus.imem_addr, 32'h0);
    check("l3_e3_valid", if_valid,      32'h0);
    tick();
    check("l3_inst0",  if_inst,  32'hA000_0000);
    check("l3_pc4_0",  if_pc4,   32'h4);
    check("l3_valid0", if_valid, 32'h1);
    check("l3_addr1",  bus.imem_addr, 32'h4);
    tick();
    check("l3_gap1", if_valid, 32'h0);
    check("l3_gap1_addr", bus.imem_addr, 32'h4);
    tick();
    check("l3_gap2", if_valid, 32'h0);
    tick();
    check("l3_inst1", if_inst, 32'hA000_0004);
    check("l3_pc4_1", if_pc4,  32'h8);
    check("l3_addr2", bus.imem_addr, 32'h8);
    tick(); tick(); tick();
    check("l3_inst2", if_inst, 32'hA000_0008);
    check("l3_pc4_2", if_pc4,  32'hC);
    tick(); tick(); tick();
    check("l3_inst3", if_inst, 32'hA000_000C);
    check("l3_addr4", bus.imem_addr, 32'h10);

    // Redirect one cycle into the 0x10 request
    stall = 1'b1;
    tick();
    check("rd_hold_inst", if_inst, 32'hA000_000C);
    redirect = 1'b1; redirect_pc = 32'h100; stall = 1'b0;
    tick();
    redirect = 1'b0;
    check("rd_flush_valid", if_valid, 32'h0);
    check("rd_flush_inst",  if_inst,  32'h0);
    check("rd_addr",        bus.imem_addr, 32'h100);
    check("rd_req",         bus.imem_req,  32'h1);
    tick();
    check("rd_drop_valid", if_valid, 32'h0);
    check("rd_drop_addr",  bus.imem_addr, 32'h100);
    tick(); tick();
    check("rd_wait_valid", if_valid, 32'h0);
    tick();
    check("rd_inst", if_inst, 32'hA000_0100);
    check("rd_pc4",  if_pc4,  32'h104);
    check("rd_next_addr", bus.imem_addr, 32'h104);

    // Redirect to FFFFFFFC together with stall and ack
    stall = 1'b1;
    tick();
    check("wr_hold_inst", if_inst, 32'hA000_0100);
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("wr_valid", if_valid, 32'h0);
    check("wr_addr",  bus.imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    check("wr_wait_valid", if_valid, 32'h0);
    tick();
    check("wr_inst",  if_inst,  32'hFFFF_FFFC);
    check("wr_pc4",   if_pc4,   32'h0);
    check("wr_valid2", if_valid, 32'h1);
    check("wr_next_addr", bus.imem_addr, 32'h0);

    // Fill to two entries under stall, then reset
    stall = 1'b1;
    tick();
    check("fl_hold", if_inst, 32'hFFFF_FFFC);
    tick(); tick();
    check("fl_req",  bus.imem_req,  32'h0);
    check("fl_addr", bus.imem_addr, 32'h4);
    check("fl_inst", if_inst,       32'hFFFF_FFFC);
    clrn = 1'b0;
    #1;
    check_reset("rst2");
    tick();
    clrn = 1'b1;
    stall = 1'b0;
    tick();
    check("rs_req",  bus.imem_req,  32'h1);
    check("rs_addr", bus.imem_addr, 32'h0);
    tick(); tick(); tick();
    check("rs_inst", if_inst, 32'hA000_0000);
    check("rs_pc4",  if_pc4,  32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
